lif_array_scheduler: RTL and testbench

//  Time-multiplexes one leaky integrate-and-fire update datapath across N_NEURONS

---
 rtl/lif_array_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_lif_array_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_array_scheduler.sv
// lif_array_scheduler
//   Time-multiplexes a single leaky integrate-and-fire update datapath across
//   N_NEURONS virtual neurons. Membrane potentials live in an internal register
//   file. A timestep sweeps every neuron in ascending order. For each neuron the
//   block fetches the input current, updates the potential, and emits a spike
//   event when the neuron fires.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   cfg_we/addr/wdata     config write: 0=threshold 1=beta_shift 2=reset_mode
//                         3=clear all membranes (accepted only when idle)
//   step_valid/ready      start one timestep (ready only in IDLE)
//   cur_valid/ready/idx   input-current handshake for neuron cur_idx
//   cur_data              unsigned 8-bit input current
//   spk_valid/ready/idx   spike event; held stable until accepted
//   busy, step_done       status; step_done is a one-cycle end-of-step pulse
//   mon_idx, mon_state    combinational membrane read-back
module lif_array_scheduler #(
  parameter int         N_NEURONS = 8,
  parameter int         IDX_W     = 3,
  parameter logic [7:0] THR_RST   = 8'd127,
  parameter logic [2:0] BETA_RST  = 3'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic             cur_valid,
  output logic             cur_ready,
  output logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       cur_data,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_idx,
  output logic             busy,
  output logic             step_done,
  input  logic [IDX_W-1:0] mon_idx,
  output logic [7:0]       mon_state
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cur_q, cur_d;
  logic [7:0]       thr_q, thr_d;
  logic [2:0]       beta_q, beta_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       mem_q [N_NEURONS];
  logic [7:0]       mem_d [N_NEURONS];

  logic [7:0]       m_shift;
  logic [8:0]       sum;
  logic [7:0]       v;
  logic [7:0]       m_new;
  logic             fire;
  logic             last;
  logic             cfg_acc;

  // Update datapath for the neuron currently addressed by idx_q.
  always_comb begin
    m_shift = mem_q[idx_q] >> beta_q;
    sum     = {1'b0, m_shift} + {1'b0, cur_q};
    v       = sum[8] ? 8'hFF : sum[7:0];
    fire    = (v >= thr_q);
    if (!fire || mode_q == 2'd0) begin
      m_new = v;
    end else if (mode_q == 2'd1) begin
      m_new = v - thr_q;  // fire implies v >= thr_q, so no underflow
    end else begin
      m_new = '0;
    end
    last = (idx_q == IDX_W'(N_NEURONS - 1));
  end

  // A step request in the same cycle as a config write takes priority.
  assign cfg_acc = cfg_we && (state_q == S_IDLE) && !step_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    thr_d   = thr_q;
    beta_d  = beta_q;
    mode_d  = mode_q;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (cfg_acc) begin
      case (cfg_addr)
        2'd0: thr_d  = cfg_wdata;
        2'd1: beta_d = cfg_wdata[2:0];
        2'd2: mode_d = cfg_wdata[1:0];
        default: begin
          for (int unsigned i = 0; i < N_NEURONS; i++) begin
            mem_d[i] = '0;
          end
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (step_valid) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (cur_valid) begin
          cur_d   = cur_data;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        mem_d[idx_q] = m_new;
        if (fire) begin
          state_d = S_EMIT;
        end else if (last) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (spk_ready) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cur_q   <= '0;
      thr_q   <= THR_RST;
      beta_q  <= BETA_RST;
      mode_q  <= 2'd1;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      thr_q   <= thr_d;
      beta_q  <= beta_d;
      mode_q  <= mode_d;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign step_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign cur_ready  = (state_q == S_FETCH);
  assign cur_idx    = idx_q;
  assign spk_valid  = (state_q == S_EMIT);
  assign spk_idx    = (state_q == S_EMIT) ? idx_q : '0;
  assign step_done  = (state_q == S_DONE);
  assign mon_state  = mem_q[mon_idx];

endmodule

// File: tb/tb_lif_array_scheduler.sv
module tb_lif_array_scheduler;
  localparam int N = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [7:0]    cfg_wdata;
  logic          step_valid;
  logic          step_ready;
  logic          cur_valid;
  logic          cur_ready;
  logic [IW-1:0] cur_idx;
  logic [7:0]    cur_data;
  logic          spk_valid;
  logic          spk_ready;
  logic [IW-1:0] spk_idx;
  logic          busy;
  logic          step_done;
  logic [IW-1:0] mon_idx;
  logic [7:0]    mon_state;

  lif_array_scheduler #(
    .N_NEURONS(N),
    .IDX_W    (IW),
    .THR_RST  (8'd127),
    .BETA_RST (3'd1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .cur_valid (cur_valid),
    .cur_ready (cur_ready),
    .cur_idx   (cur_idx),
    .cur_data  (cur_data),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .spk_idx   (spk_idx),
    .busy      (busy),
    .step_done (step_done),
    .mon_idx   (mon_idx),
    .mon_state (mon_state)
  );

  always #10 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] cur_vals [N];
  int         spk_q [$];
  int         stall_seen;
  int         cyc;

  typedef struct {
    logic [7:0] cur0;
    int         exp_m0;
    int         exp_spk;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_mon(input int i, input int exp);
    mon_idx = IW'(i);
    #1;
    check($sformatf("mon%0d", i), int'(mon_state), exp);
  endtask

  task automatic set_all_cur(input logic [7:0] val);
    for (int i = 0; i < N; i++) cur_vals[i] = val;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_we = 1'b0; step_valid = 1'b0; cur_valid = 1'b0;
    spk_ready = 1'b0; cur_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_step_ready", int'(step_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_ready", int'(cur_ready), 0);
    check("rst_spk_valid", int'(spk_valid), 0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_cur_idx", int'(cur_idx), 0);
    for (int i = 0; i < N; i++) check_mon(i, 0);
  endtask

  // One full timestep. stall_idx/stall_n: withhold cur_valid for that neuron.
  // spk_stall: cycles of spk_ready=0 per event. cfg_mode: 1 = threshold write
  // alongside step_valid, 2 = threshold write every busy cycle (both write 0).
  task automatic run_step(input int stall_idx, input int stall_n, input int spk_stall,
                          input int cfg_mode, output int cycles);
    bit pending;
    int held, wait_n, stall_left, budget;
    spk_q.delete();
    stall_seen = 0; pending = 0; held = 0; wait_n = 0;
    stall_left = stall_n; budget = 0;
    step_valid = 1'b1;
    if (cfg_mode == 1) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'd0; end
    @(posedge clk); #1;
    step_valid = 1'b0; cfg_we = 1'b0;
    cycles = 1;
    while (!step_done && budget < 1000) begin
      cur_valid = 1'b0; cur_data = '0; spk_ready = 1'b0;
      cfg_we = (cfg_mode == 2); cfg_addr = 2'd0; cfg_wdata = 8'd0;
      if (cur_ready) begin
        if (int'(cur_idx) == stall_idx) stall_seen++;
        if (int'(cur_idx) == stall_idx && stall_left > 0) stall_left--;
        else begin cur_valid = 1'b1; cur_data = cur_vals[cur_idx]; end
      end
      if (spk_valid) begin
        if (!pending) begin
          pending = 1; held = int'(spk_idx); spk_q.push_back(held); wait_n = spk_stall;
        end else begin
          check("spk_idx_stable", int'(spk_idx), held);
          check("busy_in_stall", int'(busy), 1);
        end
        if (wait_n > 0) wait_n--;
        else begin spk_ready = 1'b1; pending = 0; end
      end
      @(posedge clk); #1;
      cycles++; budget++;
    end
    check("step_completes", int'(step_done), 1);
    cur_valid = 1'b0; spk_ready = 1'b0; cfg_we = 1'b0; cur_data = '0;
    @(posedge clk); #1;
    check("idle_after_done", int'(step_ready), 1);
  endtask

  initial begin
    tbl[0] = '{cur0: 8'd64,  exp_m0: 64,  exp_spk: 0};
    tbl[1] = '{cur0: 8'd64,  exp_m0: 96,  exp_spk: 0};
    tbl[2] = '{cur0: 8'd64,  exp_m0: 112, exp_spk: 0};
    tbl[3] = '{cur0: 8'd64,  exp_m0: 120, exp_spk: 0};
    tbl[4] = '{cur0: 8'd64,  exp_m0: 124, exp_spk: 0};
    tbl[5] = '{cur0: 8'd100, exp_m0: 35,  exp_spk: 1};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    step_valid = 1'b0; cur_valid = 1'b0; cur_data = '0; spk_ready = 1'b0;
    mon_idx = '0;
    set_all_cur(8'd0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: change config, abandon a step part-way, reset restores defaults.
    cfg_write(2'd0, 8'd200);
    cfg_write(2'd1, 8'd2);
    step_valid = 1'b1; cur_valid = 1'b1; cur_data = 8'd50;
    @(posedge clk); #1;
    step_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midstep_busy", int'(busy), 1);
    check_mon(0, 50);
    do_reset();

    // 2: leak and fire with default threshold/beta/subtract mode.
    for (int s = 0; s < 6; s++) begin
      set_all_cur(8'd0);
      cur_vals[0] = tbl[s].cur0;
      run_step(-1, 0, 0, 0, cyc);
      check($sformatf("t2_m0_s%0d", s), 0, 0 * s);
      n_checks--;
      check_mon(0, tbl[s].exp_m0);
      check_mon(1, 0);
      check($sformatf("t2_nspk_s%0d", s), spk_q.size(), tbl[s].exp_spk);
      if (spk_q.size() > 0) check("t2_spk_idx", spk_q[0], 0);
      check($sformatf("t2_cycles_s%0d", s), cyc, 2 * N + 1 + tbl[s].exp_spk);
    end

    // 3: saturation (mode none keeps 255), then zero mode, then threshold 0.
    cfg_write(2'd2, 8'd0);
    set_all_cur(8'd0);
    cur_vals[0] = 8'd255;
    run_step(-1, 0, 0, 0, cyc);
    check_mon(0, 255);
    run_step(-1, 0, 0, 0, cyc);
    check_mon(0, 255);
    check("t3_sat_spk", spk_q.size(), 1);
    cfg_write(2'd2, 8'd2);
    run_step(-1, 0, 0, 0, cyc);
    check_mon(0, 0);
    check("t3_zero_spk", spk_q.size(), 1);
    cfg_write(2'd0, 8'd0);
    set_all_cur(8'd0);
    run_step(-1, 0, 0, 0, cyc);
    check("t3_thr0_nspk", spk_q.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < spk_q.size()) check($sformatf("t3_order%0d", i), spk_q[i], i);
    end
    check("t3_thr0_cycles", cyc, 3 * N + 1);

    // 4: backpressure on two spiking neurons.
    cfg_write(2'd0, 8'd127);
    cfg_write(2'd2, 8'd1);
    cfg_write(2'd3, 8'hAA);
    set_all_cur(8'd10);
    cur_vals[2] = 8'd200;
    cur_vals[5] = 8'd200;
    run_step(-1, 0, 5, 0, cyc);
    check("t4_nspk", spk_q.size(), 2);
    if (spk_q.size() == 2) begin
      check("t4_spk0", spk_q[0], 2);
      check("t4_spk1", spk_q[1], 5);
    end
    check("t4_cycles", cyc, 2 * N + 1 + 2 * 6);
    check_mon(2, 73);
    check_mon(5, 73);
    check_mon(0, 10);

    // 5: current stall on neuron 4.
    cfg_write(2'd3, 8'd0);
    set_all_cur(8'd0);
    run_step(4, 3, 0, 0, cyc);
    check("t5_cycles", cyc, 2 * N + 1 + 3);
    check("t5_idx_hold", stall_seen, 4);
    check("t5_nspk", spk_q.size(), 0);

    // 6: config gating.
    run_step(-1, 0, 0, 2, cyc);
    check("t6_busy_wr_nspk", spk_q.size(), 0);
    run_step(-1, 0, 0, 0, cyc);
    check("t6_busy_wr_after", spk_q.size(), 0);
    set_all_cur(8'd30);
    run_step(-1, 0, 0, 0, cyc);
    check_mon(3, 30);
    cfg_write(2'd3, 8'd0);
    for (int i = 0; i < N; i++) check_mon(i, 0);
    set_all_cur(8'd0);
    run_step(-1, 0, 0, 1, cyc);
    check("t6_same_cyc_nspk", spk_q.size(), 0);
    run_step(-1, 0, 0, 0, cyc);
    check("t6_same_cyc_after", spk_q.size(), 0);
    check("t6_cycles", cyc, 2 * N + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
